// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer and its helpers.
//   state_t   : sequencer FSM state encoding (ASSERT, RELEASE, RUN)
//   clog2_max : ceil(log2(max(a, b))), used to size the internal counter
package reset_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  // Smallest r with 2**r >= max(a, b). Returns 0 when max(a, b) <= 1.
  function automatic int clog2_max(input int a, input int b);
    int m;
    int r;
    m = (a > b) ? a : b;
    r = 0;
    while ((1 << r) < m) r++;
    return r;
  endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// Reset synchroniser: a chain of SYNC_STAGES flops with its data input tied
// low and every flop asynchronously preset by rst. rst_sync therefore goes
// high the instant rst rises and falls SYNC_STAGES clock edges after rst
// falls, giving a glitch-free, clock-aligned release.
//   clk      : destination clock
//   rst      : asynchronous active-high reset
//   rst_sync : synchronised active-high reset
module reset_synchronizer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic rst_sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Chip reset sequencer. Synchronises the asynchronous reset, keeps every
// domain in reset for MIN_ASSERT_CYCLES after the synchronised release, then
// frees the NUM_DOMAINS outputs one at a time, domain 0 first, one every
// STAGGER_CYCLES edges. A single-cycle sw_reset_req seen in RELEASE or RUN
// re-asserts every domain and replays the sequence.
//   clk          : system clock
//   reset        : asynchronous active-high reset (asserts immediately)
//   sw_reset_req : synchronous single-cycle software reset request
//   rst_out      : active-high domain resets, bit k drives domain k
//   busy         : high whenever the sequencer is not in RUN
//   done         : one-cycle pulse coinciding with the last domain release
//   state        : current FSM state, exported for observation
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int NUM_DOMAINS       = 4,
  parameter int MIN_ASSERT_CYCLES = 16,
  parameter int STAGGER_CYCLES    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   busy,
  output logic                   done,
  output state_t                 state
);

  localparam int CNT_WIDTH = clog2_max(MIN_ASSERT_CYCLES, STAGGER_CYCLES) + 1;
  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST  = CNT_WIDTH'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGGER_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);

  logic                   rst_sync;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [NUM_DOMAINS-1:0] next_mask;

  reset_synchronizer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (reset),
    .rst_sync(rst_sync)
  );

  // Released domains are always a contiguous run of low bits, so freeing the
  // next domain is a left shift of the still-held mask. When the shifted mask
  // is empty, the domain being freed is the last one.
  assign next_mask = rst_out << 1;

  // One counter serves both the assert hold and the stagger gaps; it is
  // cleared on every terminal compare and on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ASSERT;
      cnt     <= '0;
      rst_out <= '1;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (sw_reset_req && (state != ASSERT)) begin
        state   <= ASSERT;
        cnt     <= '0;
        rst_out <= '1;
        busy    <= 1'b1;
      end else begin
        case (state)
          ASSERT: begin
            rst_out <= '1;
            busy    <= 1'b1;
            if (rst_sync) begin
              cnt <= '0;
            end else if (cnt == ASSERT_LAST) begin
              cnt     <= '0;
              rst_out <= next_mask;
              if (next_mask == '0) begin
                state <= RUN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RELEASE: begin
            if (cnt == STAGGER_LAST) begin
              cnt     <= '0;
              rst_out <= next_mask;
              if (next_mask == '0) begin
                state <= RUN;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          RUN: begin
            cnt     <= '0;
            rst_out <= '0;
            busy    <= 1'b0;
          end

          default: begin
            state   <= ASSERT;
            cnt     <= '0;
            rst_out <= '1;
            busy    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
